// File: rtl/wb_arbiter_pkg.sv
// Shared types for the regfile write-port arbiter: source encoding, result bundle
// and the round-robin pointer step.
package wb_arbiter_pkg;

  localparam int unsigned WB_ADDR_W  = 4;
  localparam int unsigned WB_DATA_W  = 16;
  localparam int unsigned WB_NUM_SRC = 3;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_SEQ = 2'd1,
    WB_LSU = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] dest_addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Pointer moves to the source after the one just granted, wrapping LSU -> ALU.
  function automatic logic [1:0] wb_next_ptr(logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Result sources and regfile write port of the writeback arbiter. The arbiter
// uses the slave view; the execution units and regfile side use the master view.
interface wb_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) ();

  logic                   alu_valid;
  logic [ADDR_W-1:0]      alu_dest;
  logic [DATA_W-1:0]      alu_data;
  logic                   alu_ready;

  logic                   seq_valid;
  logic [ADDR_W-1:0]      seq_dest;
  logic [DATA_W-1:0]      seq_data;
  logic                   seq_ready;

  logic                   lsu_valid;
  logic [ADDR_W-1:0]      lsu_dest;
  logic [DATA_W-1:0]      lsu_data;
  logic                   lsu_ready;

  logic                   rf_we;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic [1:0]             rf_src;
  logic [(1<<ADDR_W)-1:0] pending;

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  seq_valid, seq_dest, seq_data,
    input  lsu_valid, lsu_dest, lsu_data,
    output alu_ready, seq_ready, lsu_ready,
    output rf_we, rf_waddr, rf_wdata, rf_src, pending
  );

  modport master (
    output alu_valid, alu_dest, alu_data,
    output seq_valid, seq_dest, seq_data,
    output lsu_valid, lsu_dest, lsu_data,
    input  alu_ready, seq_ready, lsu_ready,
    input  rf_we, rf_waddr, rf_wdata, rf_src, pending
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter3.sv
// Three-way round-robin grant: scans req starting at ptr, wrapping 0 -> 1 -> 2 -> 0,
// and returns the first requester as onehot and as an index.
module rr_arbiter3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] grant,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] base;
  logic [2:0] sum;
  logic [1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    sum   = '0;
    cand  = '0;
    // ptr never holds 3; treat it as ALU-first if it ever does.
    base  = (ptr == 2'd3) ? 2'd0 : ptr;
    for (int k = 0; k < 3; k++) begin
      sum = {1'b0, base} + 3'(k);
      if (sum >= 3'd3) begin
        sum = sum - 3'd3;
      end
      cand = sum[1:0];
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: one holding slot per result source, round-robin
// drain to a registered write port, and a per-register pending mask for hazards.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned ADDR_W = WB_ADDR_W
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);

  wb_req_t           src_req [WB_NUM_SRC];
  wb_req_t           hold_q  [WB_NUM_SRC];
  wb_req_t           granted;
  logic [2:0]        req;
  logic [2:0]        grant;
  logic [2:0]        ready;
  logic [2:0]        accept;
  logic [1:0]        grant_idx;
  logic              grant_any;
  logic [1:0]        ptr_q;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  wb_src_e           rf_src_q;
  logic [(1<<ADDR_W)-1:0] pending;

  always_comb begin
    src_req[0] = {bus.alu_valid, bus.alu_dest, bus.alu_data};
    src_req[1] = {bus.seq_valid, bus.seq_dest, bus.seq_data};
    src_req[2] = {bus.lsu_valid, bus.lsu_dest, bus.lsu_data};
  end

  // A slot being drained this cycle can take a new result on the same edge.
  always_comb begin
    req    = '0;
    ready  = '0;
    accept = '0;
    for (int i = 0; i < 3; i++) begin
      req[i]    = hold_q[i].valid;
      ready[i]  = !hold_q[i].valid | grant[i];
      accept[i] = src_req[i].valid & ready[i];
    end
  end

  rr_arbiter3 u_rr_arbiter3 (
    .req   (req),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    granted = hold_q[0];
    unique case (grant_idx)
      2'd1:    granted = hold_q[1];
      2'd2:    granted = hold_q[2];
      default: granted = hold_q[0];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        hold_q[i] <= '0;
      end
      ptr_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_src_q   <= WB_ALU;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept[i]) begin
          hold_q[i] <= src_req[i];
        end else if (grant[i]) begin
          hold_q[i].valid <= 1'b0;
        end
      end
      rf_we_q <= grant_any;
      if (grant_any) begin
        rf_waddr_q <= granted.dest_addr;
        rf_wdata_q <= granted.data;
        rf_src_q   <= wb_src_e'(grant_idx);
        ptr_q      <= wb_next_ptr(grant_idx);
      end
    end
  end

  // Covers results still buffered plus the one on the write port this cycle.
  always_comb begin
    pending = '0;
    for (int i = 0; i < 3; i++) begin
      if (hold_q[i].valid) begin
        pending[hold_q[i].dest_addr] = 1'b1;
      end
    end
    if (rf_we_q) begin
      pending[rf_waddr_q] = 1'b1;
    end
  end

  assign bus.alu_ready = ready[0];
  assign bus.seq_ready = ready[1];
  assign bus.lsu_ready = ready[2];
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.rf_src    = rf_src_q;
  assign bus.pending   = pending;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-port arbiter for the M1 core. The ALU, sequential unit (MUL/DIV) and LSU each return a result as destination address plus 16-bit data. This block buffers one result per source and shares the single regfile write port between them round-robin. It also exports a per-register pending mask so the issue stage can stall on RAW/WAW hazards against results not yet written.

## Interface
Parameters:
- DATA_W, 16, result/regfile data width
- ADDR_W, 4, register address width; pending mask is 2**ADDR_W bits

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result offered
- alu_dest  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU holding slot can accept
- seq_valid / seq_dest / seq_data / seq_ready  same as ALU, for MUL/DIV
- lsu_valid / lsu_dest / lsu_data / lsu_ready  same as ALU, for load data
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  ADDR_W  regfile write address (registered)
- rf_wdata  out  DATA_W  regfile write data (registered)
- rf_src  out  2  source of current write: 0 ALU, 1 SEQ, 2 LSU (registered)
- pending  out  2**ADDR_W  bit r set while a buffered or in-flight write targets r

## Operation
- One holding register per source: {hold_valid, dest, data}.
- Handshake per source i:
  - ready_i = !hold_valid[i] | grant[i] (combinational).
  - A transfer occurs on cycle edge with valid_i & ready_i; the slot loads dest/data and hold_valid[i] is set.
  - Sources hold valid/dest/data stable until ready.
- Arbitration (combinational, each cycle):
  - Requesters = hold_valid[2:0].
  - Priority order starts at pointer ptr and wraps ALU→SEQ→LSU→ALU.
  - Exactly one grant when any requester is present.
- On a grant to i:
  - rf_we<=1, rf_waddr<=dest_i, rf_wdata<=data_i, rf_src<=i.
  - hold_valid[i] clears unless refilled the same edge (grant and new accept together keep it set with new contents).
  - ptr <= (i+1) mod 3.
- No grant: rf_we<=0; rf_waddr/rf_wdata/rf_src hold their previous values; ptr unchanged.
- pending = OR over valid holding slots of onehot(dest) OR (rf_we ? onehot(rf_waddr) : 0). A bit clears the cycle after rf_we for that write drops.
- Same-destination collision: upstream issue guarantees that no two valid slots share a dest; the arbiter does not reorder for it. The bench asserts this.
- Dest 0 is written like any other register; no special-casing.

## Timing
- Reset (rst_n low, async): hold_valid=0, ptr=0 (ALU first), rf_we=0, rf_waddr=0, rf_wdata=0, rf_src=0, pending=0. All readies are 1 after reset.
- Latency: accepted at edge E, granted in the following cycle, rf_we high in the cycle after edge E+1. Two edges from offer to write with no contention.
- Throughput: one write per cycle sustained. A single source streaming alone gets one result per cycle, because ready stays 1 via grant.
- Worst-case wait: at most 2 cycles in its slot while the other two sources are granted.
- Reset asserted mid-operation drops all buffered results and clears pending immediately (async). Upstream units are reset by the same rst_n.
- Simultaneous offers from all three with empty slots: all accepted the same edge; written over the next 3 cycles in ptr order.

## Structure
- Shared package (core types):
  - wb_src_e enum {WB_ALU=0, WB_SEQ=1, WB_LSU=2}
  - wb_req_t packed struct {valid, dest_addr[ADDR_W], data[DATA_W]} for holding slots and source bundles
- Sub-module rr_arbiter3:
  - Combinational 3-way round-robin grant from req[2:0] and ptr[1:0].
  - Outputs onehot grant and encoded index.
  - Pointer register lives in wb_arbiter.
- Top holds slots, output registers and pending decode. Estimated 150-250 lines.

## Test plan
- Reset: drive alu_valid=1 during rst_n low → all readies=1, rf_we=0, pending=0. Release reset; ALU dest=3, data=16'h00AA → rf_we=1, waddr=3, wdata=00AA, rf_src=0 exactly 2 edges later.
- Three-way contention: ALU(d1,0x0011), SEQ(d2,0x0022), LSU(d4,0x0044) offered the same edge after reset → writes d1, d2, d4 on consecutive cycles. pending=0x0016 then 0x0016, 0x0014, 0x0010, 0x0000 as writes drain.
- Fairness: ALU and LSU offer continuously, SEQ idle, ptr=0 → writes alternate ALU, LSU, ALU, LSU. Neither ready stays low more than 1 consecutive cycle.
- Back-to-back single source: SEQ streams dests 5, 6, 7 on consecutive cycles → seq_ready stays 1, three consecutive rf_we cycles in order 5, 6, 7.
- Backpressure stability: ALU slot full and not granted (SEQ/LSU ahead) → alu_ready=0. A held new ALU offer is accepted only on the grant edge; no result lost or duplicated (scoreboard count match).
- Async reset mid-stream with two slots full → pending and rf_we drop to 0 without a clock edge. No write occurs after release until a new offer.
